// File: rtl/raster_frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : raster_frame_buffer_if
// Description : Pixel-stream input and row-dump output bundle of the raster
//               frame buffer. The slave modport is the frame buffer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface raster_frame_buffer_if #(
    parameter int W = 3
);
    logic               busy_i;
    logic               po_i;
    logic [W-1:0]       xo_i;
    logic [W-1:0]       yo_i;
    logic               row_valid;
    logic               row_ready;
    logic [W-1:0]       row_idx;
    logic [(1<<W)-1:0]  row_data;
    logic               frame_done;
    logic               overflow;
    logic [2*W:0]       pix_count;

    modport master (
        output busy_i, po_i, xo_i, yo_i, row_ready,
        input  row_valid, row_idx, row_data, frame_done, overflow, pix_count
    );

    modport slave (
        input  busy_i, po_i, xo_i, yo_i, row_ready,
        output row_valid, row_idx, row_data, frame_done, overflow, pix_count
    );
endinterface
`default_nettype wire

// File: rtl/raster_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : raster_frame_buffer
// Description : Double-banked 2^W x 2^W bit-plane that captures one triangle's
//               pixels and streams the finished frame out row by row.
//               W legal range 2..4. Optional set-pixel counter enabled by
//               defining RASTER_PIX_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_frame_buffer #(
    parameter int W = 3
) (
    input  wire logic            clk,
    input  wire logic            reset,
    raster_frame_buffer_if.slave bus
);
    localparam int N  = 1 << W;
    localparam int CW = 2 * W + 1;

    typedef enum logic [0:0] {
        CAP_OPEN = 1'b0,
        CAP_HELD = 1'b1
    } cap_state_t;

    typedef enum logic [0:0] {
        DMP_IDLE   = 1'b0,
        DMP_ACTIVE = 1'b1
    } dump_state_t;

    cap_state_t  r_cap_state;
    cap_state_t  w_cap_next;
    dump_state_t r_dump_state;
    dump_state_t w_dump_next;

    logic         r_busy_q;
    logic         r_cap_sel;
    logic [W-1:0] r_row_idx;
    logic         r_frame_done;
    logic         r_overflow;
    logic [N-1:0] r_bank [2][N];

    logic         w_frame_end;
    logic         w_accept;
    logic         w_last;
    logic         w_swap;
    logic         w_write;
    logic         w_wr_sel;
    logic         w_dump_sel;

    assign w_frame_end = r_busy_q & ~bus.busy_i;
    assign w_accept    = (r_dump_state == DMP_ACTIVE) & bus.row_ready;
    assign w_last      = w_accept & (r_row_idx == W'(N - 1));
    assign w_write     = bus.po_i & (r_cap_state == CAP_OPEN);
    assign w_dump_sel  = ~r_cap_sel;
    // After a swap the pixel lands in the freshly cleared bank
    assign w_wr_sel    = r_cap_sel ^ w_swap;

    always_comb begin
        w_cap_next  = r_cap_state;
        w_dump_next = r_dump_state;
        w_swap      = 1'b0;
        unique case (r_cap_state)
            CAP_OPEN: begin
                if (w_frame_end) begin
                    if ((r_dump_state == DMP_IDLE) || w_last) begin
                        w_swap = 1'b1;
                    end else begin
                        w_cap_next = CAP_HELD;
                    end
                end
            end
            CAP_HELD: begin
                if (w_last) begin
                    w_swap     = 1'b1;
                    w_cap_next = CAP_OPEN;
                end
            end
            default: begin
                w_cap_next = CAP_OPEN;
            end
        endcase
        if (w_swap) begin
            w_dump_next = DMP_ACTIVE;
        end else if (w_last) begin
            w_dump_next = DMP_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap_state  <= CAP_OPEN;
            r_dump_state <= DMP_IDLE;
        end else begin
            r_cap_state  <= w_cap_next;
            r_dump_state <= w_dump_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_q     <= 1'b0;
            r_cap_sel    <= 1'b0;
            r_row_idx    <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_busy_q     <= bus.busy_i;
            r_frame_done <= w_last;
            r_overflow   <= r_overflow | (bus.po_i & (r_cap_state == CAP_HELD));
            if (w_swap) begin
                r_cap_sel <= ~r_cap_sel;
                r_row_idx <= '0;
            end else if (w_accept) begin
                r_row_idx <= r_row_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < N; r++) begin
                    r_bank[b][r] <= '0;
                end
            end
        end else begin
            if (w_swap) begin
                for (int r = 0; r < N; r++) begin
                    r_bank[w_dump_sel][r] <= '0;
                end
            end
            // Placed after the clear so a same-cycle pixel survives it
            if (w_write) begin
                r_bank[w_wr_sel][bus.yo_i][bus.xo_i] <= 1'b1;
            end
        end
    end

`ifdef RASTER_PIX_COUNT_EN
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_pix_count;
    logic          w_new_bit;

    assign w_new_bit = w_swap | ~r_bank[r_cap_sel][bus.yo_i][bus.xo_i];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_pix_count <= '0;
        end else if (w_swap) begin
            r_pix_count <= r_cnt;
            r_cnt       <= CW'(w_write);
        end else if (w_write & w_new_bit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.pix_count = r_pix_count;
`else
    assign bus.pix_count = '0;
`endif

    assign bus.row_valid  = (r_dump_state == DMP_ACTIVE);
    assign bus.row_idx    = r_row_idx;
    assign bus.row_data   = (r_dump_state == DMP_ACTIVE) ? r_bank[w_dump_sel][r_row_idx] : '0;
    assign bus.frame_done = r_frame_done;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_raster_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_raster_frame_buffer
// Description : Randomised bench with a frame-level reference model feeding a
//               row scoreboard that a negedge monitor drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raster_frame_buffer;
    localparam int W = 3;
    localparam int N = 1 << W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    raster_frame_buffer_if #(.W(W)) bus ();
    raster_frame_buffer #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int idx;
        int data;
        int cnt;
    } row_t;

    row_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a capture frame, an optional held frame, dump progress
    int cur[N];
    bit held;
    int rows_left;
    bit busy_prev;
    bit exp_ovf;
    bit exp_done;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame();
        int c = 0;
        for (int r = 0; r < N; r++) c += $countones(cur[r]);
`ifndef RASTER_PIX_COUNT_EN
        c = 0;
`endif
        for (int r = 0; r < N; r++) begin
            exp_q.push_back('{r, cur[r], c});
            cur[r] = 0;
        end
        rows_left = N;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < N; r++) cur[r] = 0;
        held      = 0;
        rows_left = 0;
        busy_prev = 0;
        exp_ovf   = 0;
        exp_done  = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(input bit b, input bit p, input int x, input int y, input bit rdy);
        bit fe       = busy_prev && !b;
        bit was_held = held;
        bit acc      = (rows_left > 0) && rdy;
        bit last     = acc && (rows_left == 1);
        if (acc) rows_left--;
        if (!was_held && fe) begin
            if (rows_left == 0) push_frame();
            else held = 1;
        end else if (was_held && last) begin
            push_frame();
            held = 0;
        end
        if (p) begin
            if (was_held) exp_ovf = 1;
            else cur[y] |= (1 << x);
        end
        busy_prev = b;
    endfunction

    task automatic cyc(input bit b, input bit p, input int x, input int y, input bit rdy);
        bus.busy_i    = b;
        bus.po_i      = p;
        bus.xo_i      = W'(x);
        bus.yo_i      = W'(y);
        bus.row_ready = rdy;
        @(posedge clk);
        if (reset) model_reset();
        else model_step(b, p, x, y, rdy);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("frame_done", int'(bus.frame_done), int'(exp_done));
            exp_done = 0;
            chk("row_valid", int'(bus.row_valid), int'(rows_left > 0));
            chk("overflow", int'(bus.overflow), int'(exp_ovf));
            if (bus.row_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_row actual_idx=%0d required=none t=%0t", bus.row_idx, $time);
                end else begin
                    chk("row_idx", int'(bus.row_idx), exp_q[0].idx);
                    chk("row_data", int'(bus.row_data), exp_q[0].data);
                    chk("pix_count", int'(bus.pix_count), exp_q[0].cnt);
                    if (bus.row_ready) begin
                        if (exp_q[0].idx == N - 1) exp_done = 1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    bit rb;

    initial begin
        bus.busy_i = 0; bus.po_i = 0; bus.xo_i = '0; bus.yo_i = '0; bus.row_ready = 0;
        model_reset();
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_row_idx", int'(bus.row_idx), 0);
        chk("reset_row_data", int'(bus.row_data), 0);
        chk("reset_pix_count", int'(bus.pix_count), 0);

        // Basic frame
        cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 1, 2, 1);
        cyc(1, 1, 3, 2, 1);
        cyc(1, 1, 0, 7, 1);
        cyc(0, 0, 0, 0, 1);
        idle(12);

        // Duplicate pixel
        cyc(1, 1, 5, 5, 1);
        cyc(1, 1, 5, 5, 1);
        cyc(0, 0, 0, 0, 1);
        idle(12);

        // Backpressure at the start of the dump
        cyc(1, 1, 2, 3, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        idle(12);

        // Overlap: A stalled, B pending, C dropped
        cyc(1, 1, 4, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 7, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 3, 3, 0);
        cyc(1, 1, 6, 6, 0);
        cyc(0, 0, 0, 0, 0);
        idle(24);

        // Reset in the middle of a dump, then a single-pixel frame
        cyc(1, 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        do_reset();
        cyc(1, 1, 2, 4, 1);
        cyc(0, 0, 0, 0, 1);
        idle(12);

        // Random traffic
        rb = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (rb) rb = ($urandom_range(0, 5) != 0);
            else rb = ($urandom_range(0, 1) != 0);
            cyc(rb, bit'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                int'($urandom_range(0, N - 1)), ($urandom_range(0, 3) != 0));
        end
        idle(40);
        chk("drain_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/raster_frame_buffer.md
Name: raster_frame_buffer

Overview:
- Downstream consumer of the triangle rasterizer pixel stream (busy/po/xo/yo).
- Accumulates the pixels of one triangle into a 2^W x 2^W bit-plane.
- When the rasterizer's busy falls, streams the completed frame out row by row over a valid/ready interface.
- Double-banked, so capture of the next triangle overlaps with the dump of the previous one.

Parameters:
- W, 3, coordinate width; grid is 2^W x 2^W, row_data width 2^W; legal range 2..4.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- busy_i  input  1  rasterizer busy; a 1->0 transition marks frame end.
- po_i  input  1  pixel valid.
- xo_i  input  W  pixel x.
- yo_i  input  W  pixel y.
- row_valid  output  1  row_data/row_idx valid.
- row_ready  input  1  downstream accepts the row.
- row_idx  output  W  row (y) being presented.
- row_data  output  2^W  bit x = pixel (x, row_idx) set.
- frame_done  output  1  one-cycle pulse after the last row is accepted.
- overflow  output  1  sticky: pixels were dropped.
- pix_count  output  2W+1  set-pixel count of the frame being dumped (see Optional Feature).

Behaviour:
- Reset: all outputs 0; both banks cleared; busy_q=0; pending=0; capture state OPEN; dump state IDLE. A reset mid-dump aborts the dump; no frame_done is issued.
- busy_q is a registered copy of busy_i. Frame end is the cycle where busy_q=1 and busy_i=0.
- Capture bank, state OPEN:
  - po_i=1 sets bit [yo_i][xo_i] (OR semantics; duplicates are harmless).
  - po_i is honoured regardless of busy_i.
- Frame end in OPEN, dump IDLE:
  - Swap banks at that edge.
  - The new capture bank is cleared.
  - Dump goes to state DUMP with row_idx=0; row_valid is high from the next cycle.
  - A po_i on the swap cycle is written into the newly cleared capture bank; the write wins over the clear for that bit.
- Frame end in OPEN, dump DUMP:
  - pending=1 and capture goes to HELD; the bank is frozen.
- Capture state HELD:
  - po_i is dropped and sets overflow=1 (sticky until reset).
  - A further frame end while HELD is ignored.
- Dump state DUMP:
  - row_data = dump_bank[row_idx]. row_valid, row_idx and row_data hold stable while row_ready=0.
  - On row_valid&&row_ready: if row_idx < 2^W-1, increment row_idx; else the last row is accepted (see below).
- Last row accepted:
  - frame_done=1 for exactly one cycle.
  - If pending: swap banks in the same edge, clear the new capture bank, pending=0, capture to OPEN, row_idx=0. row_valid stays high, giving a back-to-back dump with no bubble.
  - Otherwise: row_valid=0 and dump goes to IDLE.
- Frame end and last-row acceptance on the same edge, no pending:
  - Treat as the pending case: swap immediately and stay in DUMP.
- Latency: frame end at edge T -> row 0 valid after T. With row_ready held 1, frame_done is asserted 2^W cycles after row 0 first appears.
- Widths: coordinates are used unsigned with no wrap; all W-bit values are legal indices.

Optional Feature:
- Macro: RASTER_PIX_COUNT_EN.
- Defined:
  - A counter increments when po_i writes a bit that was previously 0 in OPEN.
  - The counter is cleared with the capture bank and transferred to pix_count at the swap.
  - pix_count is stable for the whole dump.
- Undefined: no counter logic; pix_count tied to 0.

Test Plan:
- Basic frame: busy_i=1; pixels (1,2),(3,2),(0,7); busy_i->0; row_ready=1 -> rows 0..7 = 00,00,0A,00,00,00,00,01; frame_done pulse after row 7; pix_count=3 (0 without macro); overflow=0.
- Duplicate pixel: (5,5) sent twice, frame end -> row5=0x20, all other rows 0; pix_count=1.
- Backpressure: row_ready=0 for 5 cycles after the dump starts -> row_valid=1, row_idx=0, row_data constant throughout; then ready=1 -> the 8 rows complete in 8 cycles.
- Overlap:
  - Frame A dumps with row_ready=0.
  - Frame B (pixel (7,0)) ends -> pending.
  - Frame C pixels are dropped and overflow=1.
  - Release ready -> after A's frame_done, B's row 0=0x80 is valid in the very next cycle; C's data never appears.
- Reset mid-dump: assert reset during row 3 -> next cycle row_valid=0, overflow=0, frame_done=0; a subsequent single-pixel frame (2,4) dumps with row4=0x04, all other rows 0.
